// File: rtl/math_seq.sv
// Multi-cycle arithmetic unit: shift-add multiply, restoring divide, add and
// subtract behind a valid/ready command port and a held-result output port.
module math_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi,
    output logic             busy,
    output logic             err
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic [1:0] {OP_MUL = 2'b00, OP_DIV = 2'b01, OP_ADD = 2'b10, OP_SUB = 2'b11} op_t;

    state_t             state_q, state_d;
    op_t                op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;     // working pair: accumulator/remainder and multiplier/quotient
    logic [WIDTH-1:0]   res_lo_q, res_lo_d, res_hi_q, res_hi_d;
    logic               err_q, err_d;

    logic [WIDTH:0]     mul_sum, div_sh, add_sum;
    logic               div_ge;
    logic [WIDTH-1:0]   step_hi, step_lo;
    logic               step_err;

    // One datapath step for the captured operation, evaluated from the working registers.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
        div_sh   = {hi_q, lo_q[WIDTH-1]};
        div_ge   = (div_sh >= {1'b0, b_q});
        add_sum  = {1'b0, a_q} + {1'b0, b_q};
        step_hi  = hi_q;
        step_lo  = lo_q;
        step_err = 1'b0;
        unique case (op_q)
            OP_MUL: begin
                step_hi = mul_sum[WIDTH:1];
                step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
            end
            OP_DIV: begin
                if (b_q == '0) begin
                    step_hi  = a_q;
                    step_lo  = {WIDTH{1'b1}};
                    step_err = 1'b1;
                end else begin
                    step_hi = div_ge ? (div_sh[WIDTH-1:0] - b_q) : div_sh[WIDTH-1:0];
                    step_lo = {lo_q[WIDTH-2:0], div_ge};
                end
            end
            OP_ADD: begin
                step_hi = {{(WIDTH-1){1'b0}}, add_sum[WIDTH]};
                step_lo = add_sum[WIDTH-1:0];
            end
            OP_SUB: begin
                step_hi = (a_q < b_q) ? {WIDTH{1'b1}} : '0;
                step_lo = a_q - b_q;
            end
            default: ;
        endcase
    end

    // Next-state and register updates; nothing moves while ena is low.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        err_d    = err_q;
        if (ena) begin
            unique case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        state_d  = RUN;
                        op_d     = op_t'(cmd_op);
                        a_d      = op_a;
                        b_d      = op_b;
                        hi_d     = '0;
                        lo_d     = (op_t'(cmd_op) == OP_MUL) ? op_b : op_a;
                        cnt_d    = ((op_t'(cmd_op) == OP_MUL) || (op_t'(cmd_op) == OP_DIV && op_b != '0))
                                   ? CNT_W'(WIDTH) : CNT_W'(1);
                        res_lo_d = '0;
                        res_hi_d = '0;
                        err_d    = 1'b0;
                    end
                end
                RUN: begin
                    hi_d  = step_hi;
                    lo_d  = step_lo;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d  = DONE;
                        res_lo_d = step_lo;
                        res_hi_d = step_hi;
                        err_d    = step_err;
                    end
                end
                DONE: begin
                    if (res_ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= OP_MUL;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
            err_q    <= err_d;
        end
    end

    // cmd_ready is also gated by rst_n so it reads low while reset is held.
    assign cmd_ready = rst_n && ena && (state_q == IDLE);
    assign busy      = (state_q == RUN);
    assign res_valid = (state_q == DONE);
    assign res_lo    = res_lo_q;
    assign res_hi    = res_hi_q;
    assign err       = err_q;

endmodule

// File: tb/tb_math_seq.sv
// Self-checking bench for math_seq: directed corner cases plus random commands
// checked against an arithmetic reference model.
module tb_math_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] op_a = '0;
    logic [7:0] op_b = '0;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [7:0] res_lo;
    logic [7:0] res_hi;
    logic       busy;
    logic       err;

    int errors = 0;
    int checks = 0;

    math_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .op_a(op_a), .op_b(op_b),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_lo(res_lo), .res_hi(res_hi), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: the arithmetic result and latency of one command.
    task automatic model(input logic [1:0] op, input int a, input int b,
                         output int lo, output int hi, output int e, output int lat);
        e = 0;
        case (op)
            2'b00: begin lo = (a * b) % 256; hi = (a * b) / 256; lat = 8; end
            2'b01: begin
                if (b == 0) begin lo = 255; hi = a; e = 1; lat = 1; end
                else        begin lo = a / b; hi = a % b; lat = 8; end
            end
            2'b10: begin lo = (a + b) % 256; hi = (a + b) / 256; lat = 1; end
            default: begin lo = (a - b + 256) % 256; hi = (a < b) ? 255 : 0; lat = 1; end
        endcase
    endtask

    // Issue one command from a negedge, optionally stall 3 cycles with ena low
    // after stall_at RUN edges, hold res_ready low for hold cycles, then retire it.
    task automatic run_op(input logic [1:0] op, input int a, input int b,
                          input int stall_at, input int hold);
        int lo, hi, e, lat, edges, stall_left;
        model(op, a, b, lo, hi, e, lat);
        if (stall_at >= 0) lat += 3;
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = op; op_a = 8'(a); op_b = 8'(b);
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_op = 2'($urandom); op_a = 8'($urandom); op_b = 8'($urandom);
        edges = 0; stall_left = 0;
        while (edges < 40) begin
            @(negedge clk);
            if (res_valid) break;
            if (edges == 0) begin
                check("cleared_lo", res_lo, 0);
                check("cleared_hi", res_hi, 0);
                check("busy_run", busy, 1);
            end
            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) ena = 1'b1;
            end else if (edges == stall_at) begin
                ena = 1'b0; stall_left = 3;
            end
            @(posedge clk);
            edges++;
        end
        ena = 1'b1;
        check("latency", edges, lat);
        check("res_valid", res_valid, 1);
        check("res_lo", res_lo, lo);
        check("res_hi", res_hi, hi);
        check("err", err, e);
        check("busy_done", busy, 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", res_valid, 1);
            check("hold_lo", res_lo, lo);
            check("hold_hi", res_hi, hi);
            check("hold_err", err, e);
            check("hold_cmd_ready", cmd_ready, 0);
        end
        res_ready = 1'b1;
        check("handshake_cmd_ready", cmd_ready, 0);
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        check("retired_valid", res_valid, 0);
        check("after_cmd_ready", cmd_ready, 1);
    endtask

    initial begin
        // Power-up reset, observed before any clock edge.
        #2;
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_valid", res_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_lo", res_lo, 0);
        check("rst_hi", res_hi, 0);
        check("rst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("release_cmd_ready", cmd_ready, 1);

        // Directed corner cases.
        run_op(2'b00, 8'hFF, 8'hFF, -1, 0);
        run_op(2'b01, 200, 7, -1, 0);
        run_op(2'b01, 8'h55, 0, -1, 0);
        run_op(2'b10, 8'hF0, 8'h20, -1, 0);
        run_op(2'b11, 3, 5, -1, 5);
        run_op(2'b00, 8'hA7, 8'h3C, 2, 1);

        // Reset in the middle of a multiply.
        cmd_valid = 1'b1; cmd_op = 2'b00; op_a = 8'hC3; op_b = 8'h9E;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_valid", res_valid, 0);
        check("midrst_lo", res_lo, 0);
        check("midrst_hi", res_hi, 0);
        check("midrst_err", err, 0);
        check("midrst_cmd_ready", cmd_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(2'b00, 8'h12, 8'h34, -1, 0);

        // Random commands, with B forced to zero now and then.
        for (int n = 0; n < 24; n++) begin
            logic [1:0] op;
            int a, b, st;
            op = 2'($urandom);
            a  = int'($urandom_range(0, 255));
            b  = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(0, 255));
            st = (op == 2'b00 && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, 6)) : -1;
            run_op(op, a, b, st, int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
